// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster FP16 pixels in, packed 3x3 windows out.
// Optional macro WIN_STRIDE2_EN restricts emitted windows to stride 2.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [8:0][15:0] win_data,
    output logic             win_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

`ifdef WIN_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    localparam logic [COL_W-1:0] COL_MAX      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX      = ROW_W'(IMG_H - 1);
    // Position of the final window the chosen stride actually reaches.
    localparam logic [COL_W-1:0] COL_LAST_WIN = COL_W'(2 + STRIDE * ((IMG_W - 3) / STRIDE));
    localparam logic [ROW_W-1:0] ROW_LAST_WIN = ROW_W'(2 + STRIDE * ((IMG_H - 3) / STRIDE));

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [8:0][15:0] shift_q, shift_d;
    logic [8:0][15:0] winData_q, winData_d;
    logic             winValid_q, winValid_d;
    logic             winLast_q, winLast_d;

    logic [15:0] lb0_q [IMG_W];
    logic [15:0] lb1_q [IMG_W];
    logic [15:0] lb0Rd, lb1Rd;

    logic accept, colEnd, rowEnd, frameEnd, strideOk, qualify;

    assign in_ready  = !winValid_q || win_ready;
    assign accept    = in_valid && in_ready;
    assign colEnd    = (col_q == COL_MAX);
    assign rowEnd    = (row_q == ROW_MAX);
    assign frameEnd  = colEnd && rowEnd;
    assign lb0Rd     = lb0_q[col_q];
    assign lb1Rd     = lb1_q[col_q];

`ifdef WIN_STRIDE2_EN
    assign strideOk  = !row_q[0] && !col_q[0];
`else
    assign strideOk  = 1'b1;
`endif

    assign win_valid = winValid_q;
    assign win_data  = winData_q;
    assign win_last  = winLast_q;

    // Line buffers are read combinationally at col before this edge overwrites them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        shift_d    = shift_q;
        winData_d  = winData_q;
        winValid_d = winValid_q;
        winLast_d  = winLast_q;
        qualify    = 1'b0;

        if (accept) begin
            col_d = colEnd ? '0 : col_q + 1'b1;
            if (colEnd) begin
                row_d = rowEnd ? '0 : row_q + 1'b1;
            end

            for (int r = 0; r < 3; r++) begin
                shift_d[r*3]     = shift_q[r*3 + 1];
                shift_d[r*3 + 1] = shift_q[r*3 + 2];
            end
            shift_d[2] = lb1Rd;
            shift_d[5] = lb0Rd;
            shift_d[8] = in_data;

            case (state_q)
                FILL: begin
                    if (colEnd && row_q == ROW_W'(1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    qualify = strideOk && (col_q >= COL_W'(2));
                    if (frameEnd) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // A transfer and a new qualifying window in one cycle simply reloads.
        if (qualify) begin
            winData_d  = shift_d;
            winValid_d = 1'b1;
            winLast_d  = (row_q == ROW_LAST_WIN) && (col_q == COL_LAST_WIN);
        end else if (win_ready) begin
            winValid_d = 1'b0;
            winLast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            col_q      <= '0;
            row_q      <= '0;
            shift_q    <= '0;
            winData_q  <= '0;
            winValid_q <= 1'b0;
            winLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            shift_q    <= shift_d;
            winData_q  <= winData_d;
            winValid_q <= winValid_d;
            winLast_q  <= winLast_d;
        end
    end

endmodule
